nios_spi_slave: RTL
===================

Name: nios_spi_slave

Overview:
- SPI slave: the far-end partner of the team's 100 MHz Nios SPI master (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit).
- Used on the peripheral FPGA side, or for master loopback tests.
- The SPI pins are oversampled in the clk domain.
- A Nios CPU reaches it through an Avalon-style register port with the same register map and two-cycle access timing as the master core.

Parameters:
DATA_WIDTH, 8, bits per SPI frame (legal 4..16)
IDLE_WORD, 8'hFF, value shifted out on MISO when no TX word is primed at frame start
EOP_DEFAULT, 0, reset value of the end-of-packet value register

Ports:
clk  in  1  system clock; must be >= 8x SCLK
reset_n  in  1  asynchronous, active-low reset
SCLK  in  1  SPI clock from master (asynchronous)
SS_n  in  1  slave select from master (asynchronous)
MOSI  in  1  serial data from master (asynchronous)
MISO  out  1  serial data to master
MISO_oe  out  1  MISO output enable; 1 while selected
mem_addr  in  3  register address
data_from_cpu  in  16  write data
data_to_cpu  out  16  registered read data
read_n  in  1  active-low read
write_n  in  1  active-low write
spi_select  in  1  chip select for the register port
irq  out  1  registered interrupt
dataavailable  out  1  equals RRDY
readyfordata  out  1  equals TRDY
endofpacket  out  1  equals EOP

Behaviour:
- Reset state:
  - Outputs: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0.
  - Registers: shift, rx_holding and tx_holding all 0; bit_cnt=0; all status bits 0 except TRDY=1 and TMT=1; control=0; eop_value=EOP_DEFAULT.
  - Synchronizers reset to SCLK=0, SS_n=1, MOSI=0.
- Synchronization:
  - SCLK, SS_n and MOSI each pass through 2 flops, then an edge-detect flop.
  - Result: pin-to-action latency is 3 clk cycles.
- Register map (reads registered; valid the cycle after read_n and spi_select are sampled low):
  - 0: rx data, read-only; reading clears RRDY.
  - 1: tx data, write-only.
  - 2: status, read; any write clears EOP, RRDY, ROE and TOE.
  - 3: control; bits 9..3 are IRQ enables for EOP, E, RRDY, TRDY, TMT(reads 0), TOE, ROE.
  - 6: eop value.
  - Others read 0.
- Status layout:
  - Bit 9 EOP, 8 E=ROE|TOE, 7 RRDY, 6 TRDY, 5 TMT, 4 TOE, 3 ROE.
- Access timing:
  - Each access is a two-cycle strobe.
  - An access held longer than 2 cycles acts only once per rising edge of the strobe condition.
- TX path:
  - TRDY = ~tx_primed.
  - Write to addr 1 with TRDY=1: tx_holding <= data, tx_primed=1.
  - Write to addr 1 with TRDY=0: data is dropped and TOE=1.
  - TMT = ~frame_active & ~tx_primed.
- Frame start (synced SS_n falls, or the 8th bit completes while SS_n is still low):
  - shift <= tx_primed ? tx_holding : IDLE_WORD.
  - tx_primed cleared; bit_cnt=0; frame_active=1.
  - If a CPU write and a load land in the same cycle, the write wins: tx_primed stays 1 with the new data.
- Bit timing (mode 0):
  - MISO = shift[DATA_WIDTH-1] whenever SS_n is low; MISO_oe = ~SS_n_sync.
  - Synced SCLK rise: mosi_bit <= synced MOSI.
  - Synced SCLK fall: shift <= {shift[DATA_WIDTH-2:0], mosi_bit}; bit_cnt++.
- Word complete (fall with bit_cnt == DATA_WIDTH-1):
  - rx_holding <= shifted value; RRDY=1.
  - ROE=1 if RRDY was already 1; the old data is overwritten.
  - Frame reload as described under frame start.
- SS_n rises mid-frame:
  - Partial word is discarded: no RRDY, shift is not reloaded.
  - bit_cnt=0; frame_active=0.
  - A word loaded but unused stays consumed.
- EOP:
  - Set when a completed rx word equals eop_value[DATA_WIDTH-1:0].
  - Also set when a tx word written equals eop_value.
- Simultaneous events:
  - Status write clear and a same-cycle set: the set wins.
  - RRDY clear by a data read and a same-cycle word complete: RRDY ends at 1, ROE unchanged.
- irq (registered, 1-cycle latency) is the OR of (flag & enable) over EOP, E, RRDY, TRDY, TOE, ROE.
- SCLK edges while SS_n is high are ignored.

Test Plan:
- Write 0xA5 to addr 1, then master sends 0x3C in mode 0 at 12.5 MHz → MISO carries 1010_0101; addr 0 reads 0x003C; status reads RRDY=1, TRDY=1, TMT=1.
- No TX primed, master sends 0x81 → MISO carries 0xFF; rx 0x81; RRDY=1.
- Master sends 2 words (0x11, 0x22) without reading → ROE=1, E=1, addr 0 reads 0x0022; write status → ROE=0, RRDY=0.
- Two writes (0x55, 0x66) while idle → second write sets TOE=1; frame shifts 0x55; with control bit 4 set, irq=1 two cycles after the write.
- SS_n deasserted after 4 SCLK cycles → RRDY stays 0; next full frame 0x9A reads back correctly.
- eop_value=0x7E, master sends 0x7E with control bit 9 set → EOP=1, endofpacket=1, irq=1; status write clears all three.

Source files
------------

// File: rtl/nios_spi_slave.sv
// nios_spi_slave
//   Mode-0 (CPOL=0, CPHA=0) SPI slave, MSB first. It is the far-end partner of the Nios SPI
//   master. The SPI pins are oversampled in the clk domain. A Nios CPU reaches it through an
//   Avalon-style register port with the master's register map and two-cycle strobe timing.
//
// Ports
//   clk, reset_n           system clock (>= 8x SCLK), asynchronous active-low reset
//   SCLK, SS_n, MOSI       SPI inputs from the master (asynchronous)
//   MISO, MISO_oe          SPI data to the master and its output enable (1 while selected)
//   mem_addr               register address: 0 rx, 1 tx, 2 status, 3 control, 6 eop value
//   data_from_cpu          write data
//   data_to_cpu            registered read data
//   read_n, write_n        active-low strobes, qualified by spi_select
//   irq                    registered OR of the enabled status flags
//   dataavailable          RRDY
//   readyfordata           TRDY
//   endofpacket            EOP
module nios_spi_slave #(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(8'hFF),
   parameter logic [15:0]           EOP_DEFAULT = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe,
   input  logic [2:0]  mem_addr,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   input  logic        read_n,
   input  logic        write_n,
   input  logic        spi_select,
   output logic        irq,
   output logic        dataavailable,
   output logic        readyfordata,
   output logic        endofpacket
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   // Pin synchronizers: two flops, then one more flop for edge detection.
   logic sclk_meta, sclk_sync, sclk_prev;
   logic ss_meta, ss_sync, ss_prev;
   logic mosi_meta, mosi_sync;

   // Datapath and status state.
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] rx_holding_q, rx_holding_d;
   logic [DATA_WIDTH-1:0] tx_holding_q, tx_holding_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  frame_active_q, frame_active_d;
   logic                  tx_primed_q, tx_primed_d;
   logic                  mosi_bit_q, mosi_bit_d;
   logic                  rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, eop_q, eop_d;
   logic [9:3]            ctrl_q;
   logic [15:0]           eop_value_q;
   logic                  rd_req_q, wr_req_q;

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, word_done, frame_load;
   logic rd_req, wr_req, rd_pulse, wr_pulse;
   logic rd_rx, wr_tx, wr_status, wr_ctrl, wr_eop, tx_accept;
   logic trdy, tmt, irq_d;
   logic [DATA_WIDTH-1:0] rx_word, tx_word;
   logic [15:0]           status, rd_mux;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         ss_meta   <= 1'b1;
         ss_sync   <= 1'b1;
         ss_prev   <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sclk_meta <= SCLK;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         ss_meta   <= SS_n;
         ss_sync   <= ss_meta;
         ss_prev   <= ss_sync;
         mosi_meta <= MOSI;
         mosi_sync <= mosi_meta;
      end
   end

   // SCLK edges only count while selected; an SS_n fall takes precedence over a coincident edge.
   assign ss_fall    = ss_prev & ~ss_sync;
   assign ss_rise    = ~ss_prev & ss_sync;
   assign sclk_rise  = ~ss_sync & sclk_sync & ~sclk_prev;
   assign sclk_fall  = ~ss_sync & ~ss_fall & ~sclk_sync & sclk_prev;
   assign word_done  = sclk_fall & (bit_cnt_q == LAST_BIT);
   assign frame_load = ss_fall | word_done;
   assign rx_word    = {shift_q[DATA_WIDTH-2:0], mosi_bit_q};

   // Host strobes act once per rising edge of the qualified strobe.
   assign rd_req    = spi_select & ~read_n;
   assign wr_req    = spi_select & ~write_n;
   assign rd_pulse  = rd_req & ~rd_req_q;
   assign wr_pulse  = wr_req & ~wr_req_q;
   assign rd_rx     = rd_pulse & (mem_addr == 3'd0);
   assign wr_tx     = wr_pulse & (mem_addr == 3'd1);
   assign wr_status = wr_pulse & (mem_addr == 3'd2);
   assign wr_ctrl   = wr_pulse & (mem_addr == 3'd3);
   assign wr_eop    = wr_pulse & (mem_addr == 3'd6);
   assign tx_accept = wr_tx & ~tx_primed_q;
   assign tx_word   = data_from_cpu[DATA_WIDTH-1:0];

   assign trdy   = ~tx_primed_q;
   assign tmt    = ~frame_active_q & ~tx_primed_q;
   assign status = {6'b0, eop_q, roe_q | toe_q, rrdy_q, trdy, tmt, toe_q, roe_q, 3'b0};

   always_comb begin
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      frame_active_d = frame_active_q;
      mosi_bit_d     = mosi_bit_q;
      rx_holding_d   = rx_holding_q;
      tx_holding_d   = tx_holding_q;
      tx_primed_d    = tx_primed_q;

      if (sclk_rise) mosi_bit_d = mosi_sync;

      if (frame_load) begin
         shift_d        = tx_primed_q ? tx_holding_q : IDLE_WORD;
         bit_cnt_d      = '0;
         frame_active_d = 1'b1;
         tx_primed_d    = 1'b0;
      end else if (sclk_fall) begin
         shift_d   = rx_word;
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else if (ss_rise) begin
         // Partial word is dropped; a word already loaded stays consumed.
         bit_cnt_d      = '0;
         frame_active_d = 1'b0;
      end

      if (word_done) rx_holding_d = rx_word;

      // A write landing with a load still primes the new word.
      if (tx_accept) begin
         tx_holding_d = tx_word;
         tx_primed_d  = 1'b1;
      end
   end

   always_comb begin
      rrdy_d = rrdy_q;
      roe_d  = roe_q;
      toe_d  = toe_q;
      eop_d  = eop_q;

      // Clears first so that same-cycle sets win.
      if (wr_status) begin
         rrdy_d = 1'b0;
         roe_d  = 1'b0;
         toe_d  = 1'b0;
         eop_d  = 1'b0;
      end
      if (rd_rx) rrdy_d = 1'b0;

      if (word_done) begin
         rrdy_d = 1'b1;
         if (rrdy_q && !rd_rx) roe_d = 1'b1;
         if (rx_word == eop_value_q[DATA_WIDTH-1:0]) eop_d = 1'b1;
      end
      if (wr_tx && tx_primed_q) toe_d = 1'b1;
      if (tx_accept && (tx_word == eop_value_q[DATA_WIDTH-1:0])) eop_d = 1'b1;
   end

   always_comb begin
      case (mem_addr)
         3'd0:    rd_mux = 16'(rx_holding_q);
         3'd2:    rd_mux = status;
         3'd3:    rd_mux = {6'b0, ctrl_q, 3'b0};
         3'd6:    rd_mux = eop_value_q;
         default: rd_mux = '0;
      endcase
   end

   assign irq_d = |{eop_q & ctrl_q[9], (roe_q | toe_q) & ctrl_q[8], rrdy_q & ctrl_q[7],
                    trdy & ctrl_q[6], toe_q & ctrl_q[4], roe_q & ctrl_q[3]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q        <= '0;
         rx_holding_q   <= '0;
         tx_holding_q   <= '0;
         bit_cnt_q      <= '0;
         frame_active_q <= 1'b0;
         tx_primed_q    <= 1'b0;
         mosi_bit_q     <= 1'b0;
         rrdy_q         <= 1'b0;
         roe_q          <= 1'b0;
         toe_q          <= 1'b0;
         eop_q          <= 1'b0;
         ctrl_q         <= '0;
         eop_value_q    <= EOP_DEFAULT;
         rd_req_q       <= 1'b0;
         wr_req_q       <= 1'b0;
         data_to_cpu    <= '0;
         irq            <= 1'b0;
      end else begin
         shift_q        <= shift_d;
         rx_holding_q   <= rx_holding_d;
         tx_holding_q   <= tx_holding_d;
         bit_cnt_q      <= bit_cnt_d;
         frame_active_q <= frame_active_d;
         tx_primed_q    <= tx_primed_d;
         mosi_bit_q     <= mosi_bit_d;
         rrdy_q         <= rrdy_d;
         roe_q          <= roe_d;
         toe_q          <= toe_d;
         eop_q          <= eop_d;
         rd_req_q       <= rd_req;
         wr_req_q       <= wr_req;
         irq            <= irq_d;
         if (wr_ctrl)  ctrl_q <= {data_from_cpu[9:6], 1'b0, data_from_cpu[4:3]};
         if (wr_eop)   eop_value_q <= data_from_cpu;
         if (rd_pulse) data_to_cpu <= rd_mux;
      end
   end

   assign MISO          = ~ss_sync & shift_q[DATA_WIDTH-1];
   assign MISO_oe       = ~ss_sync;
   assign dataavailable = rrdy_q;
   assign readyfordata  = trdy;
   assign endofpacket   = eop_q;

endmodule
